// File: rtl/btn_input_conditioner_pkg.sv
// btn_input_conditioner_pkg: shared constants and debounce state type for the button/switch conditioner.
// No ports; imported by btn_input_conditioner and btn_input_conditioner_debounce.
package btn_input_conditioner_pkg;
  localparam int CAPTURE_BTN = 0;
  localparam int CLEAR_BTN   = 1;
  localparam int IN_BITS     = 4;
  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_e;
endpackage

// File: rtl/btn_input_conditioner_debounce.sv
// btn_input_conditioner_debounce: 2-FF synchroniser plus counter debouncer for one button.
// Ports: clk, rst (async, active-high); i_btn raw button; o_level debounced level;
//        o_press registered one-cycle pulse on a debounced rise; o_rise the same rise one cycle early,
//        i.e. high during the cycle whose closing edge raises o_level.
module btn_input_conditioner_debounce
  import btn_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  db_state_e     r_state;
  db_state_e     w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_level_nxt;
  logic          w_diff;
  logic          w_done;
  assign w_diff = r_sync[1] ^ r_level;
  // count of consecutive differing samples including this one; the level flips
  // on the edge where that count reaches DEBOUNCE_CYCLES
  assign w_cnt_inc = (r_state == DB_STABLE) ? CW'(1) : r_cnt + 1'b1;
  assign w_done    = w_diff && (w_cnt_inc == CW'(DEBOUNCE_CYCLES));
  assign o_rise    = w_done && !r_level;
  assign o_level   = r_level;
  assign o_press   = r_press;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    case (r_state)
      DB_STABLE: begin
        if (w_done) begin
          w_level_nxt = ~r_level;
          w_cnt_nxt   = '0;
        end else if (w_diff) begin
          w_state_nxt = DB_COUNTING;
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      DB_COUNTING: begin
        if (!w_diff) begin
          w_state_nxt = DB_STABLE;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = DB_STABLE;
          w_level_nxt = ~r_level;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = DB_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_press <= o_rise;
    end
  end
endmodule

// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: synchronises/debounces board buttons and switches and latches sw[3:0] for the CPU.
// Ports: clk, rst (async, active-high); btn raw buttons; sw raw switches; data_ack consumer took data_out;
//        btn_level debounced levels; btn_press rise pulses; sw_sync synchronised switches;
//        data_out {zeros, sw[3:0]}; data_valid unconsumed data held; overrun sticky overwrite flag.
module btn_input_conditioner
  import btn_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_BTN         = 3,
  parameter int SW_WIDTH        = 9,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  data_ack,
  output logic [NUM_BTN-1:0]    btn_level,
  output logic [NUM_BTN-1:0]    btn_press,
  output logic [SW_WIDTH-1:0]   sw_sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  overrun
);
  logic [SW_WIDTH-1:0]   r_sw_meta;
  logic [SW_WIDTH-1:0]   r_sw_sync;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovr;
  logic [NUM_BTN-1:0]    w_rise;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_ovr_nxt;
  logic                  w_cap;
  logic                  w_clr;
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    btn_input_conditioner_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn[b]),
      .o_level(btn_level[b]),
      .o_press(btn_press[b]),
      .o_rise (w_rise[b])
    );
  end
  assign w_cap = w_rise[CAPTURE_BTN];
  assign w_clr = w_rise[CLEAR_BTN];
  // clear beats capture; a capture on an ack edge treats the old word as consumed,
  // so overrun only grows when unacked data is overwritten
  always_comb begin
    w_data_nxt  = w_clr ? '0 :
                  w_cap ? {{(DATA_WIDTH-IN_BITS){1'b0}}, r_sw_sync[IN_BITS-1:0]} : r_data;
    w_valid_nxt = !w_clr && (w_cap || (r_valid && !data_ack));
    w_ovr_nxt   = w_clr ? 1'b0 :
                  w_cap ? (r_ovr | (r_valid & ~data_ack)) :
                  (r_valid && data_ack) ? 1'b0 : r_ovr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end
  assign sw_sync    = r_sw_sync;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_btn_input_conditioner.sv
// tb_btn_input_conditioner: directed table-driven bench for btn_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_btn_input_conditioner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  btn = '0;
  logic [8:0]  sw = '0;
  logic        data_ack = 1'b0;
  logic [2:0]  btn_level;
  logic [2:0]  btn_press;
  logic [8:0]  sw_sync;
  logic [15:0] data_out;
  logic        data_valid;
  logic        overrun;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  btn_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BTN(3),
    .SW_WIDTH(9),
    .DATA_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .data_ack  (data_ack),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .sw_sync   (sw_sync),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );
  typedef struct {
    int          n;
    logic [2:0]  btn;
    logic [8:0]  sw;
    logic        ack;
    logic [2:0]  lvl;
    logic [2:0]  prs;
    logic [15:0] data;
    logic        v;
    logic        o;
  } vec_t;
  vec_t tv[25];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk_all(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                         input logic [15:0] data, input logic v, input logic o);
    chk({tag, " level"}, 32'(btn_level), 32'(lvl));
    chk({tag, " press"}, 32'(btn_press), 32'(prs));
    chk({tag, " data"}, 32'(data_out), 32'(data));
    chk({tag, " valid"}, 32'(data_valid), 32'(v));
    chk({tag, " overrun"}, 32'(overrun), 32'(o));
  endtask
  initial begin
    tv[0]  = '{5, 3'b000, 9'h00A, 1'b0, 3'b111, 3'b000, 16'h0000, 1'b0, 1'b0};
    tv[1]  = '{1, 3'b000, 9'h00A, 1'b0, 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0};
    tv[2]  = '{5, 3'b001, 9'h00A, 1'b0, 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0};
    tv[3]  = '{1, 3'b001, 9'h00A, 1'b0, 3'b001, 3'b001, 16'h000A, 1'b1, 1'b0};
    tv[4]  = '{1, 3'b001, 9'h00A, 1'b0, 3'b001, 3'b000, 16'h000A, 1'b1, 1'b0};
    tv[5]  = '{5, 3'b000, 9'h003, 1'b0, 3'b001, 3'b000, 16'h000A, 1'b1, 1'b0};
    tv[6]  = '{1, 3'b000, 9'h003, 1'b0, 3'b000, 3'b000, 16'h000A, 1'b1, 1'b0};
    tv[7]  = '{1, 3'b000, 9'h003, 1'b1, 3'b000, 3'b000, 16'h000A, 1'b0, 1'b0};
    tv[8]  = '{1, 3'b000, 9'h003, 1'b1, 3'b000, 3'b000, 16'h000A, 1'b0, 1'b0};
    tv[9]  = '{5, 3'b001, 9'h003, 1'b0, 3'b000, 3'b000, 16'h000A, 1'b0, 1'b0};
    tv[10] = '{1, 3'b001, 9'h003, 1'b0, 3'b001, 3'b001, 16'h0003, 1'b1, 1'b0};
    tv[11] = '{5, 3'b000, 9'h005, 1'b0, 3'b001, 3'b000, 16'h0003, 1'b1, 1'b0};
    tv[12] = '{1, 3'b000, 9'h005, 1'b0, 3'b000, 3'b000, 16'h0003, 1'b1, 1'b0};
    tv[13] = '{5, 3'b001, 9'h005, 1'b0, 3'b000, 3'b000, 16'h0003, 1'b1, 1'b0};
    tv[14] = '{1, 3'b001, 9'h005, 1'b0, 3'b001, 3'b001, 16'h0005, 1'b1, 1'b1};
    tv[15] = '{1, 3'b000, 9'h005, 1'b1, 3'b001, 3'b000, 16'h0005, 1'b0, 1'b0};
    tv[16] = '{4, 3'b000, 9'h005, 1'b0, 3'b001, 3'b000, 16'h0005, 1'b0, 1'b0};
    tv[17] = '{1, 3'b000, 9'h007, 1'b0, 3'b000, 3'b000, 16'h0005, 1'b0, 1'b0};
    tv[18] = '{5, 3'b001, 9'h007, 1'b0, 3'b000, 3'b000, 16'h0005, 1'b0, 1'b0};
    tv[19] = '{1, 3'b001, 9'h007, 1'b0, 3'b001, 3'b001, 16'h0007, 1'b1, 1'b0};
    tv[20] = '{5, 3'b000, 9'h00C, 1'b0, 3'b001, 3'b000, 16'h0007, 1'b1, 1'b0};
    tv[21] = '{1, 3'b000, 9'h00C, 1'b0, 3'b000, 3'b000, 16'h0007, 1'b1, 1'b0};
    tv[22] = '{5, 3'b001, 9'h00C, 1'b0, 3'b000, 3'b000, 16'h0007, 1'b1, 1'b0};
    tv[23] = '{1, 3'b001, 9'h00C, 1'b1, 3'b001, 3'b001, 16'h000C, 1'b1, 1'b0};
    tv[24] = '{1, 3'b001, 9'h00C, 1'b0, 3'b001, 3'b000, 16'h000C, 1'b1, 1'b0};
    // reset with all inputs high, then release: levels rise 2+4 edges later, clear beats capture
    rst = 1'b1;
    btn = 3'b111;
    sw  = 9'h1FF;
    repeat (3) tick;
    chk_all("reset", 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    chk("reset sw_sync", 32'(sw_sync), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk_all($sformatf("rel e%0d", i), 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    end
    tick;
    chk_all("rel e6", 3'b111, 3'b111, 16'h0000, 1'b0, 1'b0);
    chk("rel sw_sync", 32'(sw_sync), 32'h1FF);
    tick;
    chk_all("rel e7", 3'b111, 3'b000, 16'h0000, 1'b0, 1'b0);
    // press / release / capture / overrun / ack vectors
    for (int i = 0; i < 25; i++)
      for (int j = 0; j < tv[i].n; j++) begin
        btn      = tv[i].btn;
        sw       = tv[i].sw;
        data_ack = tv[i].ack;
        tick;
        chk_all($sformatf("v%0d.%0d", i, j), tv[i].lvl, tv[i].prs, tv[i].data, tv[i].v, tv[i].o);
      end
    data_ack = 1'b0;
    // btn0 and btn1 rise together: clear wins over capture
    btn = 3'b000;
    repeat (6) tick;
    chk_all("clr pre", 3'b000, 3'b000, 16'h000C, 1'b1, 1'b0);
    btn = 3'b011;
    repeat (5) tick;
    chk_all("clr wait", 3'b000, 3'b000, 16'h000C, 1'b1, 1'b0);
    tick;
    chk_all("clr edge", 3'b011, 3'b011, 16'h0000, 1'b0, 1'b0);
    tick;
    chk_all("clr after", 3'b011, 3'b000, 16'h0000, 1'b0, 1'b0);
    btn = 3'b000;
    repeat (6) tick;
    chk_all("clr rel", 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    // glitch of three cycles is rejected
    btn = 3'b001;
    repeat (3) tick;
    btn = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_all($sformatf("glitch %0d", i), 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    end
    // async reset mid-count leaves no pulse behind
    btn = 3'b001;
    repeat (4) tick;
    rst = 1'b1;
    #1;
    chk_all("midrst", 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    btn = 3'b000;
    repeat (2) tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_all($sformatf("postrst %0d", i), 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
